sha1_entry_ctrl: RTL and testbench
==================================

Name: sha1_entry_ctrl

Overview:
- Sequences user entry of an 18-bit message word from five board switches and a push button.
- The word is entered as four fields: h0, h1 and h2 are 5 bits each, h3 is 3 bits. The block steps the field select itself, so there is no user-driven select.
- Once all four fields are captured, it hands the word to the SHA1 core over a valid/ready handshake, waits for the core's done pulse, then holds the result-valid indication for the display logic.
- It sits between the board I/O (switches, buttons) and the hash core.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required to accept a button level change. The board build overrides this to 1000000.
- TIMEOUT_CYCLES, 1024: maximum number of cycles to wait for core_done before flagging an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- SW  in  5  switch value for the current field.
- push  in  1  raw, asynchronous entry/advance button.
- clear  in  1  raw, asynchronous clear button, synchronised internally.
- core_ready  in  1  hash core can accept a message.
- core_done  in  1  single-cycle pulse: hash complete.
- h_sel  out  2  index of the field currently being entered (0..3).
- msg  out  18  assembled word: [4:0]=h0, [9:5]=h1, [14:10]=h2, [17:15]=h3.
- msg_valid  out  1  message offered to the core.
- busy  out  1  high in ISSUE or WAIT.
- result_valid  out  1  high in DONE with no error.
- err  out  1  timeout occurred.

Behaviour:
- Reset (rst=0, asynchronous): state=ENTRY, h_sel=0, msg=0, msg_valid=0, busy=0, result_valid=0, err=0, debouncers idle (level low).
- Button input path (push and clear):
  - 2-flop synchroniser, then debouncer.
  - The debounced level goes high after DEBOUNCE_CYCLES consecutive synced-high cycles, and low after DEBOUNCE_CYCLES consecutive synced-low cycles.
  - Rising edge of the debounced level produces a 1-cycle accept pulse.
  - Latency from raw rising edge to pulse is 2+DEBOUNCE_CYCLES cycles.
  - Bounce shorter than DEBOUNCE_CYCLES produces no pulse. Holding the button produces exactly one pulse.
- State ENTRY:
  - On push pulse: write SW into field h_sel. For h3 only SW[2:0] is used; SW[4:3] is ignored.
  - If h_sel<3: h_sel increments.
  - If h_sel==3: h_sel wraps to 0 and the state moves to ISSUE. msg_valid rises in the cycle after the h3 capture.
- State ISSUE:
  - msg_valid=1 and busy=1; msg is held stable.
  - On a cycle with msg_valid & core_ready: the transfer occurs, msg_valid drops next cycle, the timeout counter clears, and the state moves to WAIT.
  - A transfer takes at least one ISSUE cycle, even if core_ready is already high.
- State WAIT:
  - busy=1; the timeout counter increments each cycle.
  - On core_done: move to DONE with err=0.
  - If the counter reaches TIMEOUT_CYCLES-1 without core_done: move to DONE with err=1.
  - If core_done and timeout coincide, core_done wins (err=0).
- State DONE:
  - result_valid = !err; msg is held.
  - On push pulse: msg=0, h_sel=0, err=0, state returns to ENTRY.
- Clear pulse:
  - In ENTRY or DONE: msg=0, h_sel=0, err=0, state=ENTRY.
  - In ISSUE or WAIT: ignored, because the core owns the transfer.
  - Push and clear pulses in the same cycle: clear wins.
- Push pulses in ISSUE or WAIT are ignored.
- core_done outside WAIT is ignored.
- Reset mid-operation (any state, including ISSUE with msg_valid high) returns immediately to the reset values.

Decomposition:
- Shared package (sha1_board_pkg):
  - state encoding: ENTRY=0, ISSUE=1, WAIT=2, DONE=3.
  - field width constants: 5, 5, 5, 3.
  - message width: 18.
  - field bit offsets: 0, 5, 10, 15.
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, raw, level, rise_pulse), instantiated twice: once for push, once for clear.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16):
1. Debounce:
   - push high for 3 cycles then low -> no h_sel change.
   - push high for 10 cycles -> exactly one pulse, h_sel 0->1, arriving 6 cycles after the raw edge.
2. Full entry:
   - Enter SW=00110, 00110, 10011, 11101 with core_ready=1 -> msg=18'b101_10011_00110_00110.
   - msg_valid high for exactly 1 cycle, then busy=1.
   - core_done two cycles later -> result_valid=1, err=0.
3. Backpressure:
   - core_ready=0 for 5 cycles after ISSUE -> msg_valid and msg held stable for all 5 cycles.
   - Transfer occurs on the first core_ready=1 cycle.
4. Timeout:
   - core_done never asserted -> err=1, result_valid=0 after 16 WAIT cycles.
   - Then a push -> ENTRY with msg=0, err=0.
5. Clear:
   - After two fields are entered, a clear pulse -> h_sel=0, msg=0.
   - Clear pulse during WAIT -> ignored; the state still completes on core_done.
6. Async reset:
   - rst=0 asserted mid-ISSUE (not clock-aligned) -> msg_valid=0, msg=0, h_sel=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sha1_board_pkg.sv
// Shared types and constants for the SHA1 board front end: FSM encoding and message field layout.
package sha1_board_pkg;

    localparam int unsigned MSG_W      = 18;
    localparam int unsigned NUM_FIELDS = 4;
    localparam int unsigned SW_W       = 5;
    localparam int unsigned H0_W       = 5;
    localparam int unsigned H1_W       = 5;
    localparam int unsigned H2_W       = 5;
    localparam int unsigned H3_W       = 3;
    localparam int unsigned H0_LSB     = 0;
    localparam int unsigned H1_LSB     = 5;
    localparam int unsigned H2_LSB     = 10;
    localparam int unsigned H3_LSB     = 15;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Declared MSB first so h3 lands at [17:15] and h0 at [4:0].
    typedef struct packed {
        logic [H3_W-1:0] h3;
        logic [H2_W-1:0] h2;
        logic [H1_W-1:0] h1;
        logic [H0_W-1:0] h0;
    } msg_t;

    // Writes one switch value into the selected field; h3 keeps only the low bits.
    function automatic msg_t write_field(input msg_t m, input logic [1:0] sel,
                                         input logic [SW_W-1:0] sw);
        msg_t r;
        r = m;
        case (sel)
            2'd0:    r.h0 = H0_W'(sw);
            2'd1:    r.h1 = H1_W'(sw);
            2'd2:    r.h2 = H2_W'(sw);
            default: r.h3 = H3_W'(sw);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus level debouncer for a raw push button; emits one pulse per accepted press.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // The counter tracks consecutive synced cycles that disagree with the current level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            cnt        <= '0;
            rise_pulse <= 1'b0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            rise_pulse <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level      <= sync2;
                cnt        <= '0;
                rise_pulse <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sha1_entry_ctrl.sv
// Switch/button entry of an 18-bit message word and valid/ready hand-off to the SHA1 core.
module sha1_entry_ctrl
    import sha1_board_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  SW,
    input  logic        push,
    input  logic        clear,
    input  logic        core_ready,
    input  logic        core_done,
    output logic [1:0]  h_sel,
    output logic [17:0] msg,
    output logic        msg_valid,
    output logic        busy,
    output logic        result_valid,
    output logic        err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic push_level;
    logic push_pulse;
    logic clear_level;
    logic clear_pulse;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_push_db (
        .clk        (clk),
        .rst        (rst),
        .raw        (push),
        .level      (push_level),
        .rise_pulse (push_pulse)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk        (clk),
        .rst        (rst),
        .raw        (clear),
        .level      (clear_level),
        .rise_pulse (clear_pulse)
    );

    state_t             state_q, state_d;
    logic [1:0]         h_sel_q, h_sel_d;
    msg_t               msg_q, msg_d;
    logic               err_q, err_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               msg_valid_q, msg_valid_d;
    logic               busy_q, busy_d;
    logic               result_valid_q, result_valid_d;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_ENTRY;
            h_sel_q        <= 2'd0;
            msg_q          <= '0;
            err_q          <= 1'b0;
            tmo_q          <= '0;
            msg_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            h_sel_q        <= h_sel_d;
            msg_q          <= msg_d;
            err_q          <= err_d;
            tmo_q          <= tmo_d;
            msg_valid_q    <= msg_valid_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they are registered.
    always_comb begin
        state_d = state_q;
        h_sel_d = h_sel_q;
        msg_d   = msg_q;
        err_d   = err_q;
        tmo_d   = tmo_q;

        case (state_q)
            ST_ENTRY: begin
                if (clear_pulse) begin
                    msg_d   = '0;
                    h_sel_d = 2'd0;
                    err_d   = 1'b0;
                end else if (push_pulse) begin
                    msg_d = write_field(msg_q, h_sel_q, SW);
                    if (h_sel_q == 2'(NUM_FIELDS - 1)) begin
                        h_sel_d = 2'd0;
                        state_d = ST_ISSUE;
                    end else begin
                        h_sel_d = h_sel_q + 2'd1;
                    end
                end
            end
            ST_ISSUE: begin
                if (msg_valid_q && core_ready) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A done arriving on the final timeout cycle still counts as success.
                if (core_done) begin
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                if (clear_pulse || push_pulse) begin
                    msg_d   = '0;
                    h_sel_d = 2'd0;
                    err_d   = 1'b0;
                    state_d = ST_ENTRY;
                end
            end
        endcase

        msg_valid_d    = (state_d == ST_ISSUE);
        busy_d         = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
        result_valid_d = (state_d == ST_DONE) && !err_d;
    end

    assign h_sel        = h_sel_q;
    assign msg          = msg_q;
    assign msg_valid    = msg_valid_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;

endmodule

// File: tb/tb_sha1_entry_ctrl.sv
// Self-checking bench for sha1_entry_ctrl: debounce, table-driven transactions, clear and async reset.
module tb_sha1_entry_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned TMO = 16;

    logic        clk;
    logic        rst;
    logic [4:0]  SW;
    logic        push;
    logic        clear;
    logic        core_ready;
    logic        core_done;
    logic [1:0]  h_sel;
    logic [17:0] msg;
    logic        msg_valid;
    logic        busy;
    logic        result_valid;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    logic [17:0] exp_q[$];

    typedef struct {
        logic [3:0][4:0] sw;
        int              rdy_dly;
        int              done_dly;
        logic [17:0]     exp_msg;
        logic            exp_err;
    } vec_t;

    vec_t vecs[5];

    sha1_entry_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .SW           (SW),
        .push         (push),
        .clear        (clear),
        .core_ready   (core_ready),
        .core_done    (core_done),
        .h_sel        (h_sel),
        .msg          (msg),
        .msg_valid    (msg_valid),
        .busy         (busy),
        .result_valid (result_valid),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic press();
        push = 1'b1;
        repeat (7) @(negedge clk);
        push = 1'b0;
    endtask

    task automatic press_clear();
        clear = 1'b1;
        repeat (7) @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic enter(input logic [4:0] s);
        SW = s;
        press();
        settle();
    endtask

    // Scoreboard: a transfer is any cycle with msg_valid & core_ready, sampled just before the edge.
    always @(negedge clk) begin
        #4;
        if (rst && msg_valid && core_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL xfer_unexpected: got msg %0h expected no transfer at %0t", msg, $time);
            end else begin
                chk("xfer_msg", 32'(msg), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        vecs[0] = '{{5'b11101, 5'b10011, 5'b00110, 5'b00110}, 0, 2,  18'b101_10011_00110_00110, 1'b0};
        vecs[1] = '{{5'b11110, 5'b10101, 5'b00000, 5'b11111}, 5, 3,  18'b110_10101_00000_11111, 1'b0};
        vecs[2] = '{{5'b00111, 5'b00100, 5'b00010, 5'b00001}, 0, -1, 18'b111_00100_00010_00001, 1'b1};
        vecs[3] = '{{5'b11011, 5'b00100, 5'b01000, 5'b10000}, 2, 0,  18'b011_00100_01000_10000, 1'b0};
        vecs[4] = '{{5'b01010, 5'b11111, 5'b00001, 5'b01110}, 1, 15, 18'b010_11111_00001_01110, 1'b0};

        rst = 1'b0; SW = '0; push = 1'b0; clear = 1'b0; core_ready = 1'b0; core_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_h_sel", 32'(h_sel), 0);
        chk("rst_msg", 32'(msg), 0);
        chk("rst_msg_valid", 32'(msg_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b1;
        @(negedge clk);

        // Short bounce is rejected.
        SW = 5'b01010;
        push = 1'b1;
        repeat (3) @(negedge clk);
        push = 1'b0;
        repeat (10) @(negedge clk);
        chk("bounce_h_sel", 32'(h_sel), 0);

        // Held press: pulse after 6 edges, capture on the 7th, only once.
        push = 1'b1;
        repeat (6) @(negedge clk);
        chk("deb_latency_h_sel", 32'(h_sel), 0);
        @(negedge clk);
        chk("deb_h_sel", 32'(h_sel), 1);
        chk("deb_msg", 32'(msg), 32'h0000A);
        repeat (3) @(negedge clk);
        push = 1'b0;
        settle();
        chk("deb_one_pulse", 32'(h_sel), 1);

        // Second field, then clear in ENTRY.
        enter(5'b10001);
        chk("f2_h_sel", 32'(h_sel), 2);
        chk("f2_msg", 32'(msg), 32'h0022A);
        press_clear();
        chk("clr_h_sel", 32'(h_sel), 0);
        chk("clr_msg", 32'(msg), 0);
        settle();

        for (int v = 0; v < 5; v++) begin
            core_ready = (vecs[v].rdy_dly == 0);
            for (int i = 0; i < 3; i++) begin
                enter(vecs[v].sw[i]);
                chk("tbl_h_sel", 32'(h_sel), 32'(i + 1));
            end
            SW = vecs[v].sw[3];
            exp_q.push_back(vecs[v].exp_msg);
            press();
            chk("tbl_issue_valid", 32'(msg_valid), 1);
            chk("tbl_issue_busy", 32'(busy), 1);
            chk("tbl_issue_h_sel", 32'(h_sel), 0);
            for (int k = 0; k < vecs[v].rdy_dly; k++) begin
                chk("bp_valid_held", 32'(msg_valid), 1);
                chk("bp_msg_held", 32'(msg), 32'(vecs[v].exp_msg));
                @(negedge clk);
            end
            core_ready = 1'b1;
            chk("tbl_valid_at_xfer", 32'(msg_valid), 1);
            @(negedge clk);
            core_ready = 1'b0;
            chk("tbl_wait_valid", 32'(msg_valid), 0);
            chk("tbl_wait_busy", 32'(busy), 1);
            chk("tbl_sb_drained", 32'(exp_q.size()), 0);
            if (vecs[v].done_dly < 0) begin
                repeat (TMO - 1) @(negedge clk);
                chk("tmo_last_busy", 32'(busy), 1);
                chk("tmo_last_err", 32'(err), 0);
                @(negedge clk);
            end else begin
                repeat (vecs[v].done_dly) @(negedge clk);
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
            end
            chk("tbl_done_err", 32'(err), 32'(vecs[v].exp_err));
            chk("tbl_done_rv", 32'(result_valid), 32'(!vecs[v].exp_err));
            chk("tbl_done_busy", 32'(busy), 0);
            chk("tbl_done_msg", 32'(msg), 32'(vecs[v].exp_msg));
            @(negedge clk);
            chk("tbl_done_hold", 32'(result_valid), 32'(!vecs[v].exp_err));
            press();
            chk("tbl_ret_msg", 32'(msg), 0);
            chk("tbl_ret_err", 32'(err), 0);
            chk("tbl_ret_rv", 32'(result_valid), 0);
            chk("tbl_ret_h_sel", 32'(h_sel), 0);
            settle();
        end

        // Clear during WAIT is ignored; clear in DONE returns to ENTRY.
        core_ready = 1'b1;
        enter(5'b00011);
        enter(5'b00101);
        enter(5'b01001);
        SW = 5'b10110;
        exp_q.push_back(18'b110_01001_00101_00011);
        press();
        @(negedge clk);
        chk("cw_busy", 32'(busy), 1);
        core_ready = 1'b0;
        clear = 1'b1;
        repeat (8) @(negedge clk);
        clear = 1'b0;
        chk("cw_busy_after_clear", 32'(busy), 1);
        chk("cw_msg_after_clear", 32'(msg), 32'(18'b110_01001_00101_00011));
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk("cw_rv", 32'(result_valid), 1);
        chk("cw_err", 32'(err), 0);
        settle();
        press_clear();
        chk("cd_msg", 32'(msg), 0);
        chk("cd_rv", 32'(result_valid), 0);
        settle();
        chk("sb_empty", 32'(exp_q.size()), 0);

        // Asynchronous reset in the middle of ISSUE.
        core_ready = 1'b0;
        enter(5'b00001);
        enter(5'b00010);
        chk("ar_h_sel_pre", 32'(h_sel), 2);
        enter(5'b00011);
        SW = 5'b00100;
        exp_q.push_back(18'b100_00011_00010_00001);
        press();
        chk("ar_valid_pre", 32'(msg_valid), 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_msg_valid", 32'(msg_valid), 0);
        chk("ar_msg", 32'(msg), 0);
        chk("ar_h_sel", 32'(h_sel), 0);
        chk("ar_busy", 32'(busy), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        core_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("ar_post_valid", 32'(msg_valid), 0);
        chk("ar_post_msg", 32'(msg), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
